lifo_reader: RTL

//  Drain-side controller for the lifo stack: pops words via rdreq/q and re-emits them on a

---
 rtl/lifo_pkg.sv | 25 ++
 rtl/lifo_rd_skid.sv | 51 +++++
 rtl/lifo_reader.sv | 122 ++++++++++++
 3 files changed

// File: rtl/lifo_pkg.sv
// Shared types and constants for the lifo drain path.
// Reader FSM states, skid sizing, delivered-word counter width.
package lifo_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FLUSH
  } rd_state_e;

  localparam int SKID_DEPTH = 3;
  localparam int POP_CNT_W  = 16;
  localparam int PTR_W      = 2;
  localparam int OCC_W      = 2;

  localparam logic [OCC_W:0] CREDIT_MAX = (OCC_W+1)'(SKID_DEPTH);

  function automatic logic [PTR_W-1:0] ptr_inc(
    input logic [PTR_W-1:0] p
  );
    if (p == PTR_W'(SKID_DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

endpackage

// File: rtl/lifo_rd_skid.sv
// 3-entry in-order register FIFO catching words from the lifo.
// Ports: wr_i/wr_data_i push, rd_i pop, occ_o count, valid_o/head_o head.
module lifo_rd_skid
  import lifo_pkg::*;
#(
  parameter int W = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             wr_i,
  input  logic [W-1:0]     wr_data_i,
  input  logic             rd_i,
  output logic [OCC_W-1:0] occ_o,
  output logic             valid_o,
  output logic [W-1:0]     head_o
);

  logic [W-1:0]     mem_q [SKID_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [OCC_W-1:0] occ_q;
  logic             rd_ok;

  assign rd_ok   = rd_i & (occ_q != '0);
  assign occ_o   = occ_q;
  assign valid_o = (occ_q != '0);
  assign head_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < SKID_DEPTH; i++)
        mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (wr_i) begin
        mem_q[wr_ptr_q] <= wr_data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (rd_ok)
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      unique case ({wr_i, rd_ok})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

endmodule

// File: rtl/lifo_reader.sv
// Drains a lifo (rdreq/q, 1-clk latency) onto a valid/ready stream.
// Ports: enable_i, lifo_* stack side, src_* stream, busy_o, pop_cnt_o.
// LIFO_RD_LAST_EN adds src_last_o tagging the word popped at usedw==1.
module lifo_reader
  import lifo_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 enable_i,
  input  logic                 lifo_empty_i,
  input  logic [AWIDTH:0]      lifo_usedw_i,
  output logic                 lifo_rdreq_o,
  input  logic [DWIDTH-1:0]    lifo_q_i,
  output logic [DWIDTH-1:0]    src_data_o,
  output logic                 src_valid_o,
`ifdef LIFO_RD_LAST_EN
  output logic                 src_last_o,
`endif
  input  logic                 src_ready_i,
  output logic                 busy_o,
  output logic [POP_CNT_W-1:0] pop_cnt_o
);

`ifdef LIFO_RD_LAST_EN
  localparam int SW = DWIDTH + 1;
`else
  localparam int SW = DWIDTH;
`endif

  rd_state_e        state_q;
  logic             rd_pending_q;
  logic [OCC_W-1:0] occ;
  logic [SW-1:0]    wr_data;
  logic [SW-1:0]    head;
  logic             stack_go;
  logic             credit_ok;
  logic             xfer;

  // usedw and empty agree for a coherent lifo; requiring both
  // keeps a torn flag from launching a pop of nothing.
  assign stack_go = enable_i & ~lifo_empty_i & (|lifo_usedw_i);

  // Count the word still in flight so the skid can never overflow.
  assign credit_ok =
    ({1'b0, occ} + {{OCC_W{1'b0}}, rd_pending_q}) < CREDIT_MAX;

  assign lifo_rdreq_o = (state_q == DRAIN) & stack_go & credit_ok;
  assign xfer         = src_valid_o & src_ready_i;
  assign busy_o       = (state_q != IDLE);

`ifdef LIFO_RD_LAST_EN
  logic last_pending_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      last_pending_q <= 1'b0;
    else
      last_pending_q <= lifo_rdreq_o &
        (lifo_usedw_i == (AWIDTH+1)'(1));
  end

  assign wr_data    = {last_pending_q, lifo_q_i};
  assign src_data_o = head[DWIDTH-1:0];
  assign src_last_o = head[DWIDTH] & src_valid_o;
`else
  assign wr_data    = lifo_q_i;
  assign src_data_o = head;
`endif

  lifo_rd_skid #(
    .W (SW)
  ) u_skid (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .wr_i      (rd_pending_q),
    .wr_data_i (wr_data),
    .rd_i      (src_ready_i),
    .occ_o     (occ),
    .valid_o   (src_valid_o),
    .head_o    (head)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      rd_pending_q <= 1'b0;
    else
      rd_pending_q <= lifo_rdreq_o;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      unique case (state_q)
        IDLE:
          if (stack_go)
            state_q <= DRAIN;
        DRAIN:
          if (!stack_go)
            state_q <= FLUSH;
        FLUSH:
          if (stack_go && !rd_pending_q)
            state_q <= DRAIN;
          else if (!rd_pending_q && occ == '0)
            state_q <= IDLE;
        default:
          state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      pop_cnt_o <= '0;
    else if (xfer)
      pop_cnt_o <= pop_cnt_o + POP_CNT_W'(1);
  end

endmodule
